integral_image_builder: RTL and testbench
=========================================

// Module: integral_image_builder
// PURPOSE
//  Streams a 160x120 grayscale frame in raster order and computes its integral image
//  II(x,y) = sum of pix(i,j) over i<=x, j<=y. Each II value is written to the
//  integral-image buffer that the Haar classifiers read from.
//  Sits directly upstream of the buffer/classifiers. Its frame_done pulse tells the
//  detection state machine that a complete, consistent II is available.
// PARAMETERS
//  IMG_W      160  pixels per line
//  IMG_H      120  lines per frame
//  PIX_W      4    input pixel width, unsigned (grayscale 0..15)
//  II_W       21   II word width, signed, matches classifier data_in
//  ADDR_W     15   buffer address width
// PORTS
//  clk          in   1       system clock; single clock domain
//  rst          in   1       synchronous, active-high reset
//  frame_start  in   1       marks pixel (0,0) of a new frame; qualified by pix_valid
//  pix_valid    in   1       pix_in valid this cycle; gaps are allowed
//  pix_in       in   PIX_W   pixel value, unsigned
//  freeze       in   1       hold off new frames while detection runs (only with II_FREEZE_EN)
//  wr_en        out  1       buffer write strobe
//  wr_addr      out  ADDR_W  buffer address = y*IMG_W + x
//  wr_data      out  II_W    signed II value, always >= 0
//  busy         out  1       frame in progress (state FILL)
//  frame_done   out  1       one-cycle pulse after the last write of a complete frame
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, x=y=0, row_sum=0. Line-buffer contents are don't-care.
//  - States:
//    IDLE -> FILL on (pix_valid & frame_start); that pixel is processed as (0,0).
//    FILL -> DONE after pixel (IMG_W-1, IMG_H-1) is accepted.
//    DONE -> IDLE after 1 cycle.
//  - In IDLE, pixels arriving without frame_start are ignored (no write).
//  - Per accepted pixel at (x,y):
//    row_sum' = (x==0 ? 0 : row_sum) + zext(pix_in)
//    ii       = row_sum' + (y==0 ? 0 : line_buf[x])
//    line_buf[x] <= ii   (IMG_W x II_W register array holding the previous row's II)
//  - Latency: wr_en/wr_addr/wr_data are registered and appear 1 cycle after the
//    accepted pixel. wr_en is low in every cycle without an accepted pixel.
//  - x wraps to 0 and y increments at x==IMG_W-1. Pixel gaps hold all state unchanged.
//  - frame_done is asserted in the DONE cycle. This is the same cycle as the last wr_en
//    (addr 19199). busy is low in that cycle.
//  - Arithmetic: maximum II = 160*120*15 = 288000 < 2^20, so no overflow is possible.
//    Sums are computed unsigned at II_W and output as signed with MSB 0.
//  - frame_start with pix_valid while in FILL: the current frame is abandoned with no
//    frame_done, counters restart, and this pixel is (0,0). Previously written
//    addresses are overwritten as the new frame proceeds.
//  - frame_start without pix_valid has no effect.
//  - Reset mid-frame: returns to IDLE immediately. No further writes occur and no
//    frame_done is pulsed.
// CONFIGURATION
//  II_FREEZE_EN defined:
//    - IDLE -> FILL additionally requires !freeze. Frames starting while freeze=1 are
//      dropped in full: no writes occur for them, even if freeze falls mid-frame.
//    - A frame already in FILL completes normally regardless of freeze.
//  II_FREEZE_EN undefined:
//    - The freeze port exists but is ignored.
//    - Frames are always accepted, and the buffer may change while a detection is running.
// STRUCTURE
//  - Shared package: IMG_W, IMG_H, II_W, ADDR_W, PIX_W, the state encoding
//    (IDLE/FILL/DONE, one-hot 3'b001/010/100), and an address-of(x,y) function.
//    These are reused by the classifiers and the detection state machine.
//  - One sub-module: ii_line_buffer (IMG_W x II_W, one combinational read port and
//    one synchronous write port at the same index).
//  - Counters, row_sum and the FSM live in the top-level module.
// TESTING
//  1. Constant frame, pix=1, no gaps -> addr 0=1, addr 159=160, addr 160=2,
//     addr 19199=19200; exactly 19200 writes; one frame_done.
//  2. Constant frame, pix=15 -> addr 19199=288000; wr_data[20] is never 1.
//  3. Ramp pix=x%16 with random pix_valid gaps -> every write matches a software II
//     model; write order is strictly ascending.
//  4. frame_start re-asserted at pixel (10,5) -> no frame_done for the aborted frame;
//     next write is addr 0 with value pix(0,0); the new frame completes normally.
//  5. rst asserted at (80,60) -> the next cycle has wr_en=0, busy=0, frame_done=0;
//     pixels without frame_start are ignored until the next frame_start.
//  6. II_FREEZE_EN: freeze=1 at frame start -> zero writes for that frame;
//     freeze=0 before the next frame_start -> full frame written and frame_done pulsed.

Source files
------------

// File: rtl/integral_image_builder_pkg.sv
// integral_image_builder_pkg
//   Shared constants for the integral-image path: frame geometry, II word
//   width, buffer address width, the builder state encoding and the
//   raster address helper. Also imported by the Haar classifiers and the
//   detection state machine.
package integral_image_builder_pkg;

    localparam int IMG_W  = 160;  // pixels per line
    localparam int IMG_H  = 120;  // lines per frame
    localparam int PIX_W  = 4;    // unsigned grayscale pixel
    localparam int II_W   = 21;   // II word, signed at the consumer, MSB always 0
    localparam int ADDR_W = 15;   // buffer address
    localparam int X_W    = 8;    // column counter width
    localparam int Y_W    = 7;    // row counter width

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        FILL = 3'b010,
        DONE = 3'b100
    } ii_state_e;

    // Buffer address of pixel (x,y) in raster order.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        return ADDR_W'(y) * ADDR_W'(IMG_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/integral_image_builder_line_buffer.sv
// ii_line_buffer
//   One row of II values (IMG_W x II_W registers), holding the previous
//   row's integral while the current row is built. Contents are not reset.
// Ports
//   clk      in   system clock
//   idx_i    in   column index, shared by the read and the write port
//   we_i     in   write strobe
//   wdata_i  in   II value written at idx_i on the clock edge
//   rdata_o  out  combinational read of entry idx_i
module ii_line_buffer
    import integral_image_builder_pkg::*;
(
    input  logic             clk,
    input  logic [X_W-1:0]   idx_i,
    input  logic             we_i,
    input  logic [II_W-1:0]  wdata_i,
    output logic [II_W-1:0]  rdata_o
);

    logic [II_W-1:0] mem_q [IMG_W];

    assign rdata_o = mem_q[idx_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/integral_image_builder.sv
// integral_image_builder
//   Streams a 160x120 4-bit grayscale frame in raster order and writes its
//   integral image II(x,y) (sum over i<=x, j<=y) to the II buffer, one
//   registered write per accepted pixel at address y*IMG_W+x.
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   frame_start  in   marks pixel (0,0), qualified by pix_valid
//   pix_valid    in   pix_in valid this cycle (gaps allowed)
//   pix_in       in   unsigned pixel
//   freeze       in   hold off new frames (only with II_FREEZE_EN)
//   wr_en        out  buffer write strobe, 1 cycle after the accepted pixel
//   wr_addr      out  buffer address
//   wr_data      out  II value, signed, always >= 0
//   busy         out  frame in progress (FILL)
//   frame_done   out  pulse in the cycle of the last write of a full frame
// Configuration
//   II_FREEZE_EN  when defined, a frame may only start while freeze is low;
//                 otherwise freeze is ignored.
module integral_image_builder
    import integral_image_builder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_in,
    input  logic                    freeze,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic signed [II_W-1:0]  wr_data,
    output logic                    busy,
    output logic                    frame_done
);

    ii_state_e          state_q, state_d;
    logic [X_W-1:0]     x_q, x_d, x_cur;
    logic [Y_W-1:0]     y_q, y_d, y_cur;
    logic [II_W-1:0]    row_sum_q, row_sum_d;
    logic [II_W-1:0]    row_sum_new, lb_rdata, ii;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [II_W-1:0]    wr_data_q;
    logic               start_ok, accept, restart, last_pix;

`ifdef II_FREEZE_EN
    assign start_ok = pix_valid & frame_start & ~freeze;
`else
    logic unused_freeze;
    assign unused_freeze = freeze;
    assign start_ok      = pix_valid & frame_start;
`endif

    // Pixel acceptance. A frame_start inside FILL restarts the frame at (0,0).
    always_comb begin
        accept  = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept  = start_ok;
                restart = start_ok;
            end
            FILL: begin
                accept  = pix_valid;
                restart = pix_valid & frame_start;
            end
            default: ;
        endcase
    end

    // Coordinates of the pixel being accepted this cycle.
    assign x_cur    = restart ? '0 : x_q;
    assign y_cur    = restart ? '0 : y_q;
    assign last_pix = (x_cur == X_LAST) && (y_cur == Y_LAST);

    // Max II is 288000 < 2^20, so unsigned II_W sums never reach the MSB.
    assign row_sum_new = ((x_cur == '0) ? '0 : row_sum_q)
                         + {{(II_W-PIX_W){1'b0}}, pix_in};
    assign ii          = row_sum_new + ((y_cur == '0) ? '0 : lb_rdata);

    ii_line_buffer u_line_buf (
        .clk     (clk),
        .idx_i   (x_cur),
        .we_i    (accept),
        .wdata_i (ii),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = last_pix ? DONE : FILL;
            FILL:    if (accept && last_pix) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        row_sum_d = row_sum_q;
        if (accept) begin
            row_sum_d = row_sum_new;
            if (x_cur == X_LAST) begin
                x_d = '0;
                y_d = last_pix ? '0 : y_cur + 1'b1;
            end else begin
                x_d = x_cur + 1'b1;
                y_d = y_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            row_sum_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_sum_q <= row_sum_d;
            wr_en_q   <= accept;
            if (accept) begin
                wr_addr_q <= addr_of(x_cur, y_cur);
                wr_data_q <= ii;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q == FILL);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_integral_image_builder.sv
// tb_integral_image_builder
//   Self-checking bench for integral_image_builder. Expected writes come
//   from a column-sum II model and are queued when pixels are driven; the
//   write monitor pops and compares them on the falling clock edge.
module tb_integral_image_builder;
    import integral_image_builder_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              pix_valid = 1'b0;
    logic [3:0]        pix_in = '0;
    logic              freeze = 1'b0;
    logic              wr_en;
    logic [14:0]       wr_addr;
    logic signed [20:0] wr_data;
    logic              busy;
    logic              frame_done;

    integral_image_builder dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_in      (pix_in),
        .freeze      (freeze),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    typedef struct {
        int ramp;       // 1: pix = x%16, 0: pix = val
        int val;
        int gap;        // idle cycle inserted with probability 1/gap (0: none)
        int abort_px;   // pixels of an abandoned frame sent first (0: none)
        int frz_mid;    // raise freeze during the second half of the frame
        int exp_writes;
        int exp_last;   // II at address 19199
    } frame_t;

    typedef struct {
        int addr;
        int val;
    } spot_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   wr_count = 0;
    int   done_count = 0;
    int   last_addr = -1;
    int   wr_mem [19200];

    // Reference model state
    bit   m_active = 1'b0;
    bit   m_done_cycle = 1'b0;
    int   mx = 0;
    int   my = 0;
    int   colsum [160];

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
            end
            check("wr_data_msb", int'(wr_data[20]), 0);
            if (wr_addr != 0) check("ascending", int'(int'(wr_addr) > last_addr), 1);
            last_addr = int'(wr_addr);
            if (wr_addr < 15'd19200) wr_mem[wr_addr] = int'(wr_data);
            wr_count++;
        end
        if (frame_done) begin
            done_count++;
            check("done_last_addr", wr_en ? int'(wr_addr) : -1, 19199);
            check("done_busy", int'(busy), 0);
        end
    end

    // Drive one cycle of inputs and advance the model for the upcoming edge.
    task automatic drive(input bit v, input bit fs, input logic [3:0] p, input bit fr);
        exp_t e;
        bit   frz;
        int   ii;
        pix_valid   = v;
        frame_start = fs;
        pix_in      = p;
        freeze      = fr;
`ifdef II_FREEZE_EN
        frz = fr;
`else
        frz = 1'b0;
`endif
        if (m_done_cycle) begin
            m_done_cycle = 1'b0;
        end else if (v) begin
            if (fs && (m_active || !frz)) begin
                m_active = 1'b1;
                mx = 0;
                my = 0;
                for (int i = 0; i < 160; i++) colsum[i] = 0;
            end
            if (m_active) begin
                colsum[mx] += int'(p);
                ii = 0;
                for (int i = 0; i <= mx; i++) ii += colsum[i];
                e.addr = my * 160 + mx;
                e.data = ii;
                exp_q.push_back(e);
                if (mx == 159) begin
                    mx = 0;
                    if (my == 119) begin
                        my = 0;
                        m_active = 1'b0;
                        m_done_cycle = 1'b1;
                    end else begin
                        my++;
                    end
                end else begin
                    mx++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    frame_t frames [3];
    spot_t  spots [6];

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w0;
        int d0;
        logic [3:0] p;

        frames[0] = '{ramp: 0, val: 1,  gap: 0, abort_px: 0,   frz_mid: 0,
                      exp_writes: 19200, exp_last: 19200};
        frames[1] = '{ramp: 0, val: 15, gap: 0, abort_px: 810, frz_mid: 0,
                      exp_writes: 20010, exp_last: 288000};
        frames[2] = '{ramp: 1, val: 0,  gap: 8, abort_px: 0,   frz_mid: 1,
                      exp_writes: 19200, exp_last: 144000};
        spots[0] = '{addr: 0,     val: 1};
        spots[1] = '{addr: 159,   val: 160};
        spots[2] = '{addr: 160,   val: 2};
        spots[3] = '{addr: 319,   val: 320};
        spots[4] = '{addr: 9680,  val: 4941};
        spots[5] = '{addr: 19199, val: 19200};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr_en", int'(wr_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        idle(2);

`ifdef II_FREEZE_EN
        // Frame offered while frozen is dropped in full, even after freeze falls.
        w0 = wr_count;
        drive(1'b1, 1'b1, 4'd5, 1'b1);
        for (int k = 1; k < 300; k++) drive(1'b1, 1'b0, 4'd5, k < 50);
        check("freeze_busy", int'(busy), 0);
        idle(3);
        check("freeze_writes", wr_count - w0, 0);
`endif

        for (int f = 0; f < 3; f++) begin
            w0 = wr_count;
            d0 = done_count;
            for (int k = 0; k < frames[f].abort_px; k++)
                drive(1'b1, k == 0, 4'(frames[f].val), 1'b0);
            for (int y = 0; y < 120; y++) begin
                for (int x = 0; x < 160; x++) begin
                    if (frames[f].gap > 0)
                        while ($urandom_range(frames[f].gap - 1, 0) == 0)
                            drive(1'b0, 1'b0, 4'd0, frames[f].frz_mid != 0 && y >= 60);
                    p = (frames[f].ramp != 0) ? 4'(x % 16) : 4'(frames[f].val);
                    drive(1'b1, (x == 0 && y == 0), p, frames[f].frz_mid != 0 && y >= 60);
                    if (x == 0 && y == 0) check("busy_fill", int'(busy), 1);
                end
            end
            idle(4);
            check("frame_queue_empty", exp_q.size(), 0);
            check("frame_writes", wr_count - w0, frames[f].exp_writes);
            check("frame_done_count", done_count - d0, 1);
            check("frame_last_ii", wr_mem[19199], frames[f].exp_last);
            if (f == 0)
                for (int s = 0; s < 6; s++)
                    check("spot_ii", wr_mem[spots[s].addr], spots[s].val);
        end

        // Reset at pixel (80,60): nothing further is written, no frame_done.
        w0 = wr_count;
        d0 = done_count;
        for (int k = 0; k < 60 * 160 + 80; k++) drive(1'b1, k == 0, 4'd3, 1'b0);
        rst         = 1'b1;
        pix_valid   = 1'b1;
        frame_start = 1'b0;
        pix_in      = 4'd3;
        @(posedge clk);
        #1;
        m_active = 1'b0;
        m_done_cycle = 1'b0;
        check("rst_mid_wr_en", int'(wr_en), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_frame_done", int'(frame_done), 0);
        rst = 1'b0;
        for (int k = 0; k < 200; k++) drive(1'b1, 1'b0, 4'd7, 1'b0);
        idle(3);
        check("rst_mid_busy_after", int'(busy), 0);
        check("rst_mid_writes", wr_count - w0, 60 * 160 + 80);
        check("rst_mid_done_count", done_count - d0, 0);
        check("rst_mid_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
